mips_regfile_mp: RTL and testbench

- Parametrised multi-port register file for the pipelined MIPS core.
- Successor to the single-write, two-read register file. Adds:
  - NUM_RD read ports and two write ports.
  - Same-edge write-to-read bypass.
  - Register 0 hardwired to zero.
  - Synchronous reset with a stack-pointer preset.
  - A per-register pending-write scoreboard used by hazard detection.
- Sits between decode (read ports, scoreboard set) and writeback (write ports).

---
 rtl/mips_regfile_mp.sv | 75 +++++++
 tb/tb_mips_regfile_mp.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_regfile_mp.sv
// Multi-port MIPS register file: NUM_RD read ports, two write ports, r0 hardwired to zero, pending-write scoreboard.
// One-cycle registered reads with write-first bypass; no backpressure, every port is accepted every cycle.
module mips_regfile_mp #(
    parameter int                  DATA_W   = 32,
    parameter int                  ADDR_W   = 5,
    parameter int                  NUM_RD   = 2,
    parameter int                  SP_INDEX = 29,
    parameter logic [DATA_W-1:0]   SP_INIT  = '0
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [NUM_RD*ADDR_W-1:0]   Read_Reg,
    output logic [NUM_RD*DATA_W-1:0]   Read_Data,
    output logic [NUM_RD-1:0]          Read_Busy,
    input  logic                       Write_En_0,
    input  logic [ADDR_W-1:0]          Write_Reg_0,
    input  logic [DATA_W-1:0]          Write_Data_0,
    input  logic                       Write_En_1,
    input  logic [ADDR_W-1:0]          Write_Reg_1,
    input  logic [DATA_W-1:0]          Write_Data_1,
    input  logic                       Busy_Set,
    input  logic [ADDR_W-1:0]          Busy_Set_Reg
);

    localparam int                DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] SP_IDX = ADDR_W'(SP_INDEX);

    logic [DATA_W-1:0] regs     [DEPTH];
    logic [DATA_W-1:0] regs_nxt [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;

    // Port 1 is applied after port 0 so it wins on a shared index; a new
    // producer's set is applied last so it survives a same-edge retirement.
    always_comb begin
        regs_nxt = regs;
        busy_nxt = busy;
        if (Write_En_0 && (Write_Reg_0 != '0)) begin
            regs_nxt[Write_Reg_0] = Write_Data_0;
            busy_nxt[Write_Reg_0] = 1'b0;
        end
        if (Write_En_1 && (Write_Reg_1 != '0)) begin
            regs_nxt[Write_Reg_1] = Write_Data_1;
            busy_nxt[Write_Reg_1] = 1'b0;
        end
        if (Busy_Set && (Busy_Set_Reg != '0)) begin
            busy_nxt[Busy_Set_Reg] = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            if (SP_IDX != '0) begin
                regs[SP_IDX] <= SP_INIT;
            end
            busy      <= '0;
            Read_Data <= '0;
            Read_Busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= regs_nxt[i];
            end
            busy <= busy_nxt;
            // Reads see the post-edge state, giving same-edge write-to-read bypass.
            for (int k = 0; k < NUM_RD; k++) begin
                Read_Data[k*DATA_W +: DATA_W] <= regs_nxt[Read_Reg[k*ADDR_W +: ADDR_W]];
                Read_Busy[k]                  <= busy_nxt[Read_Reg[k*ADDR_W +: ADDR_W]];
            end
        end
    end

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Drives a default (2x32) and a wide (4x64) register file with identical stimulus and
// compares both against an array-based reference model every cycle.
module tb_mips_regfile_mp;

    localparam logic [31:0] SP_N = 32'h7FFF_FFF0;
    localparam logic [63:0] SP_W = 64'h0000_7FFF_FFFF_FF00;

    logic        Clock;
    logic        rst;
    logic        we0, we1, bs;
    logic [4:0]  wr0, wr1, bsr;
    logic [63:0] wd0, wd1;
    logic [4:0]  rr [4];

    logic [63:0]  rd_n;
    logic [1:0]   rb_n;
    logic [255:0] rd_w;
    logic [3:0]   rb_w;
    logic [9:0]   rreg_n;
    logic [19:0]  rreg_w;

    assign rreg_n = {rr[1], rr[0]};
    assign rreg_w = {rr[3], rr[2], rr[1], rr[0]};

    mips_regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .SP_INDEX(29), .SP_INIT(SP_N)) u_dut_n (
        .Clock(Clock), .Reset(rst), .Read_Reg(rreg_n), .Read_Data(rd_n), .Read_Busy(rb_n),
        .Write_En_0(we0), .Write_Reg_0(wr0), .Write_Data_0(wd0[31:0]),
        .Write_En_1(we1), .Write_Reg_1(wr1), .Write_Data_1(wd1[31:0]),
        .Busy_Set(bs), .Busy_Set_Reg(bsr)
    );

    mips_regfile_mp #(.DATA_W(64), .ADDR_W(5), .NUM_RD(4), .SP_INDEX(29), .SP_INIT(SP_W)) u_dut_w (
        .Clock(Clock), .Reset(rst), .Read_Reg(rreg_w), .Read_Data(rd_w), .Read_Busy(rb_w),
        .Write_En_0(we0), .Write_Reg_0(wr0), .Write_Data_0(wd0),
        .Write_En_1(we1), .Write_Reg_1(wr1), .Write_Data_1(wd1),
        .Busy_Set(bs), .Busy_Set_Reg(bsr)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Reference model: architectural register contents and pending-producer flags.
    logic [31:0] mem_n [32];
    logic [63:0] mem_w [32];
    logic        pend  [32];
    logic [31:0] exp_n  [2];
    logic        exp_bn [2];
    logic [63:0] exp_w  [4];
    logic        exp_bw [4];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                mem_n[i] = '0;
                mem_w[i] = '0;
                pend[i]  = 1'b0;
            end
            mem_n[29] = SP_N;
            mem_w[29] = SP_W;
            for (int k = 0; k < 2; k++) begin exp_n[k] = '0; exp_bn[k] = 1'b0; end
            for (int k = 0; k < 4; k++) begin exp_w[k] = '0; exp_bw[k] = 1'b0; end
        end else begin
            // Writes land in order port 0 then port 1; a new producer then marks busy.
            if (we0 && wr0 != 0) begin mem_n[wr0] = wd0[31:0]; mem_w[wr0] = wd0; pend[wr0] = 1'b0; end
            if (we1 && wr1 != 0) begin mem_n[wr1] = wd1[31:0]; mem_w[wr1] = wd1; pend[wr1] = 1'b0; end
            if (bs && bsr != 0) pend[bsr] = 1'b1;
            for (int k = 0; k < 2; k++) begin exp_n[k] = mem_n[rr[k]]; exp_bn[k] = pend[rr[k]]; end
            for (int k = 0; k < 4; k++) begin exp_w[k] = mem_w[rr[k]]; exp_bw[k] = pend[rr[k]]; end
        end
    endtask

    task automatic cycle();
        @(posedge Clock);
        model_edge();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("n_data%0d", k), {32'h0, rd_n[k*32 +: 32]}, {32'h0, exp_n[k]});
            chk($sformatf("n_busy%0d", k), {63'h0, rb_n[k]}, {63'h0, exp_bn[k]});
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("w_data%0d", k), rd_w[k*64 +: 64], exp_w[k]);
            chk($sformatf("w_busy%0d", k), {63'h0, rb_w[k]}, {63'h0, exp_bw[k]});
        end
    endtask

    task automatic idle();
        rst = 0; we0 = 0; we1 = 0; bs = 0;
        wr0 = 0; wr1 = 0; bsr = 0; wd0 = '0; wd1 = '0;
    endtask

    task automatic set_reads(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c, input logic [4:0] d);
        rr[0] = a; rr[1] = b; rr[2] = c; rr[3] = d;
    endtask

    initial begin
        idle();
        set_reads(0, 0, 0, 0);
        rst = 1;
        @(negedge Clock);
        cycle();
        chk("reset_rd0", {32'h0, rd_n[31:0]}, 64'h0);
        chk("reset_busy", {62'h0, rb_n}, 64'h0);

        // Reset values of SP and an ordinary register.
        idle();
        set_reads(29, 5, 29, 5);
        cycle();
        chk("sp_init_n", {32'h0, rd_n[31:0]}, {32'h0, SP_N});
        chk("sp_init_w", rd_w[63:0], SP_W);
        chk("r5_zero", {32'h0, rd_n[63:32]}, 64'h0);

        // Same-edge bypass of a port-0 write.
        we0 = 1; wr0 = 8; wd0 = 64'hCAFE_F00D_DEAD_BEEF;
        set_reads(8, 8, 8, 0);
        cycle();
        chk("bypass8", {32'h0, rd_n[31:0]}, 64'h0000_0000_DEAD_BEEF);
        chk("bypass8_w", rd_w[63:0], 64'hCAFE_F00D_DEAD_BEEF);
        idle();
        cycle();
        chk("hold8", {32'h0, rd_n[31:0]}, 64'h0000_0000_DEAD_BEEF);

        // Both ports hit reg 9: port 1 wins, including on the bypass.
        we0 = 1; wr0 = 9; wd0 = 64'h1111_1111_1111_1111;
        we1 = 1; wr1 = 9; wd1 = 64'h2222_2222_2222_2222;
        set_reads(9, 9, 9, 9);
        cycle();
        chk("prio9_bypass", {32'h0, rd_n[31:0]}, 64'h0000_0000_2222_2222);
        idle();
        cycle();
        chk("prio9_hold", rd_w[255:192], 64'h2222_2222_2222_2222);

        // Register 0 ignores writes and busy marking.
        we0 = 1; wr0 = 0; wd0 = '1;
        we1 = 1; wr1 = 0; wd1 = '1;
        bs = 1; bsr = 0;
        set_reads(0, 0, 0, 0);
        cycle();
        idle();
        cycle();
        chk("r0_data", {32'h0, rd_n[31:0]}, 64'h0);
        chk("r0_busy", {63'h0, rb_n[0]}, 64'h0);

        // Scoreboard: set, set-beats-clear, then clear.
        bs = 1; bsr = 12;
        set_reads(12, 12, 12, 12);
        cycle();
        chk("busy12_set", {63'h0, rb_n[0]}, 64'h1);
        idle();
        we1 = 1; wr1 = 12; wd1 = 64'h5; bs = 1; bsr = 12;
        cycle();
        chk("busy12_setwins", {63'h0, rb_n[1]}, 64'h1);
        idle();
        we0 = 1; wr0 = 12; wd0 = 64'h6;
        cycle();
        chk("busy12_clear", {63'h0, rb_n[0]}, 64'h0);

        // Mid-run reset discards writes, busy flags and any same-cycle write.
        idle();
        we0 = 1; wr0 = 3; wd0 = 64'h33;
        we1 = 1; wr1 = 4; wd1 = 64'h44;
        bs = 1; bsr = 7;
        cycle();
        idle();
        rst = 1; we0 = 1; wr0 = 3; wd0 = 64'h99;
        cycle();
        idle();
        set_reads(3, 4, 7, 29);
        cycle();
        chk("rst_r3", {32'h0, rd_n[31:0]}, 64'h0);
        chk("rst_r4", {32'h0, rd_n[63:32]}, 64'h0);
        chk("rst_r7_w", rd_w[191:128], 64'h0);
        chk("rst_busy_w", {60'h0, rb_w}, 64'h0);
        chk("rst_sp_w", rd_w[255:192], SP_W);

        // Randomised traffic concentrated on a few indices to provoke collisions.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            we0 = $urandom_range(0, 1);
            we1 = $urandom_range(0, 1);
            bs  = $urandom_range(0, 2) == 0;
            wr0 = 5'($urandom_range(0, 7));
            wr1 = 5'($urandom_range(0, 7));
            bsr = 5'($urandom_range(0, 7));
            wd0 = {$urandom, $urandom};
            wd1 = {$urandom, $urandom};
            for (int k = 0; k < 4; k++) begin
                rr[k] = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
